// File: rtl/fetch_thread_scheduler.sv
// Fetch thread scheduler: round-robin with burst quantum, one-shot
// mispredict priority slot, and per-thread I-cache miss blocking.
module fetch_thread_scheduler #(
  parameter int unsigned BURST_LEN = 2
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Stall,
  input  logic [3:0] i_thread_active,
  input  logic [3:0] i_queue_full,
  input  logic       i_miss_valid,
  input  logic [1:0] i_miss_thread,
  input  logic       i_refill_done,
  input  logic [1:0] i_refill_thread,
  input  logic [3:0] i_branch_mispredict,
  output logic [1:0] o_thread_choice,
  output logic       o_fetch_valid,
  output logic [3:0] o_thread_blocked
);

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned TID_W       = 2;
  localparam int unsigned CNT_W       = 4;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  logic [TID_W-1:0]       r_choice;
  logic                   r_valid;
  logic [NUM_THREADS-1:0] r_blocked;
  logic [TID_W-1:0]       r_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_slot_valid;
  logic [TID_W-1:0]       r_slot_thread;

  logic [NUM_THREADS-1:0] w_miss_mask;
  logic [NUM_THREADS-1:0] w_refill_mask;
  logic [NUM_THREADS-1:0] w_elig;
  logic [NUM_THREADS-1:0] w_ptr_mask;
  logic                   w_others;
  logic [TID_W-1:0]       w_scan_idx;
  logic                   w_found;
  logic                   w_sel_valid;
  logic [TID_W-1:0]       w_sel_thread;
  logic [TID_W-1:0]       w_sel_ptr;
  logic [CNT_W-1:0]       w_sel_count;
  logic                   w_slot_take;
  logic                   w_unused_taken;

  // The taken bit is carried on the mispredict bus but not needed here.
  assign w_unused_taken = i_branch_mispredict[2];

  // Decode miss/refill thread ids and compute per-thread eligibility.
  always_comb begin
    w_miss_mask   = '0;
    w_refill_mask = '0;
    w_ptr_mask    = '0;
    if (i_miss_valid)  w_miss_mask[i_miss_thread]     = 1'b1;
    if (i_refill_done) w_refill_mask[i_refill_thread] = 1'b1;
    w_ptr_mask[r_ptr] = 1'b1;
    // A miss this cycle masks its thread immediately; a refill only takes effect next cycle.
    w_elig   = i_thread_active & ~i_queue_full & ~(r_blocked | w_miss_mask);
    w_others = |(w_elig & ~w_ptr_mask);
  end

  // Grant selection: priority slot, then burst regrant, then round-robin scan.
  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_thread = r_choice;
    w_sel_ptr    = r_ptr;
    w_sel_count  = '0;
    w_slot_take  = 1'b0;
    w_found      = 1'b0;
    w_scan_idx   = r_ptr;
    if (r_slot_valid && w_elig[r_slot_thread]) begin
      w_sel_valid  = 1'b1;
      w_sel_thread = r_slot_thread;
      w_sel_ptr    = r_slot_thread;
      w_sel_count  = CNT_W'(1);
      w_slot_take  = 1'b1;
    end else if ((r_count != '0) && w_elig[r_ptr] &&
                 ((r_count < BURST_MAX) || !w_others)) begin
      // A nonzero count means a burst is in progress on r_ptr.
      w_sel_valid  = 1'b1;
      w_sel_thread = r_ptr;
      w_sel_count  = (r_count < BURST_MAX) ? (r_count + CNT_W'(1)) : BURST_MAX;
    end else if (|w_elig) begin
      for (int i = 1; i <= 4; i++) begin
        w_scan_idx = r_ptr + TID_W'(i);
        if (!w_found && w_elig[w_scan_idx]) begin
          w_found      = 1'b1;
          w_sel_valid  = 1'b1;
          w_sel_thread = w_scan_idx;
          w_sel_ptr    = w_scan_idx;
          w_sel_count  = CNT_W'(1);
        end
      end
    end
  end

  // State update: block flags and slot always, grant state only when not stalled.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_choice      <= '0;
      r_valid       <= 1'b0;
      r_blocked     <= '0;
      r_ptr         <= TID_W'(3);
      r_count       <= '0;
      r_slot_valid  <= 1'b0;
      r_slot_thread <= '0;
    end else begin
      r_blocked <= (r_blocked & ~w_refill_mask) | w_miss_mask;
      if (i_branch_mispredict[3]) begin
        r_slot_valid  <= 1'b1;
        r_slot_thread <= i_branch_mispredict[1:0];
      end else if (r_slot_valid &&
                   (!i_thread_active[r_slot_thread] || (w_slot_take && !i_Stall))) begin
        r_slot_valid <= 1'b0;
      end
      if (!i_Stall) begin
        r_choice <= w_sel_thread;
        r_valid  <= w_sel_valid;
        r_ptr    <= w_sel_ptr;
        r_count  <= w_sel_count;
      end
    end
  end

  assign o_thread_choice  = r_choice;
  assign o_fetch_valid    = r_valid;
  assign o_thread_blocked = r_blocked;

endmodule

// File: tb/tb_fetch_thread_scheduler.sv
// Directed self-checking bench for fetch_thread_scheduler (BURST_LEN=2).
module tb_fetch_thread_scheduler;

  logic       i_Clk = 1'b0;
  logic       i_Reset_n;
  logic       i_Stall;
  logic [3:0] i_thread_active;
  logic [3:0] i_queue_full;
  logic       i_miss_valid;
  logic [1:0] i_miss_thread;
  logic       i_refill_done;
  logic [1:0] i_refill_thread;
  logic [3:0] i_branch_mispredict;
  logic [1:0] o_thread_choice;
  logic       o_fetch_valid;
  logic [3:0] o_thread_blocked;

  int checks = 0;
  int errors = 0;

  fetch_thread_scheduler #(.BURST_LEN(2)) dut (
    .i_Clk               (i_Clk),
    .i_Reset_n           (i_Reset_n),
    .i_Stall             (i_Stall),
    .i_thread_active     (i_thread_active),
    .i_queue_full        (i_queue_full),
    .i_miss_valid        (i_miss_valid),
    .i_miss_thread       (i_miss_thread),
    .i_refill_done       (i_refill_done),
    .i_refill_thread     (i_refill_thread),
    .i_branch_mispredict (i_branch_mispredict),
    .o_thread_choice     (o_thread_choice),
    .o_fetch_valid       (o_fetch_valid),
    .o_thread_blocked    (o_thread_blocked)
  );

  always #5 i_Clk = ~i_Clk;

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] ec, input logic ev, input logic [3:0] eb);
    checks++;
    assert (o_thread_choice === ec) else begin
      errors++;
      $error("FAIL %s choice got %0d exp %0d", tag, o_thread_choice, ec);
    end
    checks++;
    assert (o_fetch_valid === ev) else begin
      errors++;
      $error("FAIL %s valid got %0b exp %0b", tag, o_fetch_valid, ev);
    end
    checks++;
    assert (o_thread_blocked === eb) else begin
      errors++;
      $error("FAIL %s blocked got %b exp %b", tag, o_thread_blocked, eb);
    end
  endtask

  int exp_rr[9]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_miss[6] = '{2, 2, 3, 3, 0, 0};
  int exp_ref[6]  = '{2, 3, 3, 0, 0, 1};

  initial begin
    i_Reset_n = 1'b0; i_Stall = 1'b0; i_thread_active = 4'hF; i_queue_full = 4'h0;
    i_miss_valid = 1'b0; i_miss_thread = 2'd0; i_refill_done = 1'b0; i_refill_thread = 2'd0;
    i_branch_mispredict = 4'h0;
    tick(); tick();
    chk("reset", 2'd0, 1'b0, 4'b0000);

    // Plain round robin with burst of two.
    i_Reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr", 2'(exp_rr[i]), 1'b1, 4'b0000);
    end

    // Miss on thread 1 while thread 0 is granted.
    i_miss_valid = 1'b1; i_miss_thread = 2'd1;
    tick();
    chk("miss_set", 2'd0, 1'b1, 4'b0010);
    i_miss_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("miss_skip", 2'(exp_miss[i]), 1'b1, 4'b0010);
    end

    // Refill thread 1; it rejoins on the following rotation.
    i_refill_done = 1'b1; i_refill_thread = 2'd1;
    tick();
    chk("refill", 2'd2, 1'b1, 4'b0000);
    i_refill_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("refill_rr", 2'(exp_ref[i]), 1'b1, 4'b0000);
    end

    // Mispredict on thread 3 during thread-1 burst.
    i_branch_mispredict = 4'b1011;
    tick();
    chk("mp_load", 2'd1, 1'b1, 4'b0000);
    i_branch_mispredict = 4'h0;
    tick();
    chk("mp_grant", 2'd3, 1'b1, 4'b0000);
    tick();
    chk("mp_burst", 2'd3, 1'b1, 4'b0000);
    tick();
    chk("mp_after", 2'd0, 1'b1, 4'b0000);

    // Only thread 2 active: regranted indefinitely.
    i_thread_active = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sole", 2'd2, 1'b1, 4'b0000);
    end
    i_queue_full = 4'hF;
    tick();
    chk("full0", 2'd2, 1'b0, 4'b0000);
    tick();
    chk("full1", 2'd2, 1'b0, 4'b0000);
    i_queue_full = 4'h0; i_thread_active = 4'hF;
    tick();
    chk("resume", 2'd3, 1'b1, 4'b0000);
    tick();
    chk("resume2", 2'd3, 1'b1, 4'b0000);

    // Stall with a miss on thread 0 inside.
    i_Stall = 1'b1;
    tick();
    chk("stall0", 2'd3, 1'b1, 4'b0000);
    i_miss_valid = 1'b1; i_miss_thread = 2'd0;
    tick();
    chk("stall1", 2'd3, 1'b1, 4'b0001);
    i_miss_valid = 1'b0;
    tick();
    chk("stall2", 2'd3, 1'b1, 4'b0001);
    i_Stall = 1'b0;
    tick();
    chk("unstall", 2'd1, 1'b1, 4'b0001);

    // Miss and refill on the same thread in the same cycle: set wins.
    i_miss_valid = 1'b1; i_miss_thread = 2'd0;
    i_refill_done = 1'b1; i_refill_thread = 2'd0;
    tick();
    chk("set_wins", 2'd1, 1'b1, 4'b0001);
    i_miss_valid = 1'b0;
    tick();
    chk("refill0", 2'd2, 1'b1, 4'b0000);
    i_refill_done = 1'b0;

    // Reset mid-burst with a slot load and a miss pending.
    i_Reset_n = 1'b0;
    i_branch_mispredict = 4'b1001;
    i_miss_valid = 1'b1; i_miss_thread = 2'd2;
    tick();
    chk("rst_mid", 2'd0, 1'b0, 4'b0000);
    i_Reset_n = 1'b1; i_branch_mispredict = 4'h0; i_miss_valid = 1'b0;
    tick();
    chk("post_rst0", 2'd0, 1'b1, 4'b0000);
    tick();
    chk("post_rst1", 2'd0, 1'b1, 4'b0000);
    tick();
    chk("post_rst2", 2'd1, 1'b1, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
